// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shift engine and its step stage.
package shift_pkg;

  localparam int W = 8;

  typedef enum logic [2:0] {
    SH_LSR = 3'd0,
    SH_ASR = 3'd1,
    SH_LSL = 3'd2,
    SH_ROR = 3'd3,
    SH_ROL = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } eng_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-pass shift stage of 0..8 positions, built as a
// funnel shifter: {hi, lo} is shifted right and the low W bits are kept.
module shift_step
  import shift_pkg::*;
(
  input  logic [W-1:0] a,
  input  shift_op_t    op,
  input  logic [3:0]   n,
  output logic [W-1:0] o
);

  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [3:0]   sh;

  // Map the operation onto funnel inputs; left shifts use 8-n on the right funnel.
  always_comb begin
    hi = '0;
    lo = a;
    sh = 4'd0;
    case (op)
      SH_LSR: begin hi = '0;           lo = a;  sh = n;         end
      SH_ASR: begin hi = {W{a[W-1]}};  lo = a;  sh = n;         end
      SH_LSL: begin hi = a;            lo = '0; sh = 4'd8 - n;  end
      SH_ROR: begin hi = a;            lo = a;  sh = n;         end
      SH_ROL: begin hi = a;            lo = a;  sh = 4'd8 - n;  end
      // Unknown op codes pass the operand through unchanged.
      default: begin hi = '0;          lo = a;  sh = 4'd0;      end
    endcase
  end

  // The funnel output is truncated to W bits; results never widen.
  always_comb begin
    o = W'({hi, lo} >> sh);
  end

endmodule

// File: rtl/iter_shift_engine.sv
// Multi-cycle shift unit: accepts one request, applies at most STEP_MAX
// positions per cycle through a single shift_step, then presents the result.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the engine only accepts in IDLE and holds out_data stable in
// DONE until out_ready is seen.
module iter_shift_engine
  import shift_pkg::*;
#(
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = 7
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  shift_op_t        in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy
);

  eng_state_t       state;
  eng_state_t       state_nxt;
  logic [W-1:0]     acc;
  logic [AMT_W-1:0] rem;
  shift_op_t        op_q;
  logic [3:0]       step_n;
  logic [W-1:0]     step_out;

  // Distance for this pass: the remaining amount clipped to STEP_MAX.
  always_comb begin
    step_n = (rem > AMT_W'(STEP_MAX)) ? 4'(STEP_MAX) : rem[3:0];
  end

  shift_step u_step (
    .a  (acc),
    .op (op_q),
    .n  (step_n),
    .o  (step_out)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = BUSY;
      BUSY:    if (rem == '0)     state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: capture on accept, then one clipped pass per BUSY cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc  <= '0;
      rem  <= '0;
      op_q <= SH_LSR;
    end else if (state == IDLE && in_valid) begin
      acc  <= in_data;
      rem  <= in_amt;
      op_q <= in_op;
    end else if (state == BUSY && rem != '0) begin
      acc  <= step_out;
      rem  <= rem - AMT_W'(step_n);
    end
  end

  assign out_data = acc;

endmodule

// File: tb/tb_iter_shift_engine.sv
// Self-checking bench for iter_shift_engine with a whole-amount reference model.
module tb_iter_shift_engine;
  import shift_pkg::*;

  localparam int STEP_MAX = 7;

  logic       clk;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  shift_op_t  in_op;
  logic [4:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  iter_shift_engine #(.AMT_W(5), .STEP_MAX(STEP_MAX)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the full shift applied in one go with integer arithmetic.
  function automatic logic [7:0] model_res(input logic [7:0] x, input int op, input int amt);
    int xi;
    int sx;
    int r;
    xi = int'(x);
    sx = (xi >= 128) ? xi - 256 : xi;
    r  = amt % 8;
    case (op)
      0:       return 8'(xi >> amt);
      1:       return 8'(sx >>> amt);
      2:       return 8'(xi << amt);
      3:       return 8'((xi >> r) | (xi << (8 - r)));
      4:       return 8'((xi << r) | (xi >> (8 - r)));
      default: return x;
    endcase
  endfunction

  function automatic int model_lat(input int amt);
    return (amt + STEP_MAX - 1) / STEP_MAX + 1;
  endfunction

  // One full request: accept, wait for result, optionally stall, then drain.
  task automatic do_req(input string name, input logic [7:0] d, input int op, input int amt,
                        input logic [7:0] exp_d, input int exp_lat, input int hold);
    int edges;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_op     = shift_op_t'(op);
    in_amt    = 5'(amt);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept_ready got=%b want=1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_op    = shift_op_t'($urandom_range(0, 7));
    in_amt   = 5'($urandom);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    total++;
    if (edges != exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", name, edges, exp_lat);
    end
    total++;
    if (out_data !== exp_d) begin
      bad++;
      $display("FAIL %s data got=%02h want=%02h", name, out_data, exp_d);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold%0d got v=%b d=%02h r=%b want v=1 d=%02h r=0",
                 name, i, out_valid, out_data, in_ready, exp_d);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release got r=%b v=%b b=%b want r=1 v=0 b=0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s got r=%b v=%b d=%02h b=%b want r=1 v=0 d=00 b=0",
               name, in_ready, out_valid, out_data, busy);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_op = SH_LSR; in_amt = 5'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_reset");
  endtask

  task automatic test_directed();
    do_req("lsl_81_3",  8'h81, 2, 3,  8'h08, 2, 0);
    do_req("asr_80_20", 8'h80, 1, 20, 8'hFF, 4, 0);
    do_req("lsr_80_20", 8'h80, 0, 20, 8'h00, 4, 0);
    do_req("ror_96_12", 8'h96, 3, 12, 8'h69, 3, 0);
    do_req("rol_96_1",  8'h96, 4, 1,  8'h2D, 2, 0);
    do_req("lsr_f0_0",  8'hF0, 0, 0,  8'hF0, 1, 0);
    do_req("lsl_01_31", 8'h01, 2, 31, 8'h00, 6, 0);
    do_req("asr_7f_31", 8'h7F, 1, 31, 8'h00, 6, 0);
    do_req("rol_c3_16", 8'hC3, 4, 16, 8'hC3, 4, 0);
    do_req("ill_5a_9",  8'h5A, 6, 9,  8'h5A, 3, 0);
  endtask

  task automatic test_backpressure();
    int edges;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h81; in_op = SH_LSL; in_amt = 5'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    // Pending second request stays asserted through DONE.
    in_data = 8'h3C; in_op = SH_ROL; in_amt = 5'd2;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    total++;
    if (edges != 2) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=2", edges);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h08 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall%0d got v=%b d=%02h r=%b want v=1 d=08 r=0",
                 i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got r=%b v=%b b=%b want r=1 v=0 b=0", in_ready, out_valid, busy);
    end
    in_valid = 1'b0;
    // The pending request must now be taken as a fresh transaction.
    do_req("bp_pending", 8'h3C, 4, 2, 8'hF0, 2, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h80; in_op = SH_ASR; in_amt = 5'd20; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy got=%b want=1", busy);
    end
    #2;
    nrst = 1'b0;
    #1;
    check_reset_vals("midrst_async");
    @(negedge clk);
    nrst = 1'b1;
    do_req("midrst_after", 8'h96, 3, 12, 8'h69, 3, 0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int last_acc;
    int gaps;
    cyc = 0; last_acc = -1; gaps = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5; in_op = SH_ROR; in_amt = 5'd9; out_ready = 1'b1;
    while (gaps < 3 && cyc < 100) begin
      if (in_ready === 1'b1) begin
        if (last_acc >= 0) begin
          gaps++;
          total++;
          if (cyc - last_acc != 5) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d want=5", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      if (out_valid === 1'b1) begin
        total++;
        if (out_data !== 8'hD2) begin
          bad++;
          $display("FAIL b2b_data got=%02h want=d2", out_data);
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (gaps < 3) begin
      bad++;
      $display("FAIL b2b_timeout got=%0d want=3", gaps);
    end
    in_valid = 1'b0;
    // Drain whatever is in flight.
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d;
    int op;
    int amt;
    for (int k = 0; k < 40; k++) begin
      d   = 8'($urandom);
      op  = $urandom_range(0, 7);
      amt = $urandom_range(0, 31);
      do_req($sformatf("rand%0d", k), d, op, amt, model_res(d, op, amt), model_lat(amt),
             $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
